// File: rtl/prince_rand_gen_if.sv
// rtl/prince_rand_gen_if.sv - seed/step/randomness bundle for prince_rand_gen
interface prince_rand_gen_if #(
  parameter int NBYTES = 27
);
  logic [7:0]          seed_in;
  logic                seed_valid;
  logic                seed_ready;
  logic                reseed;
  logic                en;
  logic [8*NBYTES-1:0] r;
  logic                r_valid;

  // Cipher / seeding side: supplies seed bytes and step requests, consumes r
  modport master (
    output seed_in, seed_valid, reseed, en,
    input  seed_ready, r, r_valid
  );

  // Generator side
  modport slave (
    input  seed_in, seed_valid, reseed, en,
    output seed_ready, r, r_valid
  );
endinterface

// File: rtl/prince_rand_gen.sv
// rtl/prince_rand_gen.sv - serially seeded byte-wise LFSR randomness source
module prince_rand_gen #(
  parameter int NBYTES = 27,
  parameter int TAP1   = 3,
  parameter int TAP2   = 12
) (
  input logic             clk,
  input logic             rst,
  prince_rand_gen_if.slave rif
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  logic [0:0]    state_q;
  logic [W-1:0]  s_q;
  logic [CW-1:0] cnt_q;

  logic          accept;
  logic          last_byte;
  logic [W-1:0]  load_shift;
  logic [7:0]    fb;
  logic [W-1:0]  step_shift;

  // Handshake and next-value helpers; the state register itself is r
  always_comb begin
    rif.seed_ready = (state_q == ST_LOAD) & ~rst;
    rif.r_valid    = (state_q == ST_RUN);
    rif.r          = s_q;
    accept         = rif.seed_valid & rif.seed_ready;
    last_byte      = (cnt_q == CNT_LAST);
    load_shift     = {rif.seed_in, s_q[W-1:8]};
    fb             = s_q[7:0] ^ s_q[8*TAP1 +: 8] ^ s_q[8*TAP2 +: 8] ^ s_q[W-8 +: 8];
    step_shift     = {fb, s_q[W-1:8]};
  end

  // Load/run sequencing: serial seed shift-in, then invertible LFSR stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (rif.reseed) begin
            cnt_q <= '0;
          end else if (accept) begin
            if (last_byte) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
              // an all-zero state is a fixed point of the LFSR, so never enter RUN with it
              s_q     <= (load_shift == '0) ? W'(1) : load_shift;
            end else begin
              s_q   <= load_shift;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (rif.reseed) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end else if (rif.en) begin
            s_q <= step_shift;
          end
        end
        default: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prince_rand_gen.sv
// tb/tb_prince_rand_gen.sv - randomized self-checking bench for prince_rand_gen
module tb_prince_rand_gen;

  localparam int NB = 27;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prince_rand_gen_if #(.NBYTES(NB)) rif ();

  prince_rand_gen #(.NBYTES(NB), .TAP1(3), .TAP2(12)) dut (
    .clk (clk),
    .rst (rst),
    .rif (rif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: array of bytes, a seed counter and a running flag
  logic [7:0] m_b [NB];
  int         m_cnt;
  bit         m_run;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] m_word();
    logic [W-1:0] v;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = m_b[i];
    return v;
  endfunction

  task automatic m_shift_in(input logic [7:0] nb);
    for (int i = 0; i < NB - 1; i++) m_b[i] = m_b[i+1];
    m_b[NB-1] = nb;
  endtask

  task automatic m_clock(input bit r_i, input bit sv, input logic [7:0] sin, input bit rs, input bit e);
    bit allz;
    if (r_i) begin
      for (int i = 0; i < NB; i++) m_b[i] = 8'h00;
      m_cnt = 0;
      m_run = 0;
    end else if (!m_run) begin
      if (rs) m_cnt = 0;
      else if (sv) begin
        m_shift_in(sin);
        if (m_cnt == NB - 1) begin
          m_run = 1;
          m_cnt = 0;
          allz = 1;
          for (int i = 0; i < NB; i++) if (m_b[i] != 0) allz = 0;
          if (allz) m_b[0] = 8'h01;
        end else m_cnt++;
      end
    end else begin
      if (rs) begin
        m_run = 0;
        m_cnt = 0;
      end else if (e) begin
        m_shift_in(m_b[0] ^ m_b[3] ^ m_b[12] ^ m_b[NB-1]);
      end
    end
  endtask

  // One clock: drive inputs, advance model, sample 1ns after the edge
  task automatic cyc(input bit r_i, input bit sv, input logic [7:0] sin, input bit rs, input bit e);
    rst            = r_i;
    rif.seed_valid = sv;
    rif.seed_in    = sin;
    rif.reseed     = rs;
    rif.en         = e;
    @(posedge clk);
    m_clock(r_i, sv, sin, rs, e);
    #1;
    check("r", rif.r, m_word());
    check("r_valid", W'(rif.r_valid), W'(m_run));
    check("seed_ready", W'(rif.seed_ready), W'(!m_run && !r_i));
  endtask

  logic [W-1:0] exp_w;
  logic [W-1:0] hold_w;
  logic [7:0]   rb [NB];
  int           k;

  initial begin
    rif.seed_in = 8'h00; rif.seed_valid = 1'b0; rif.reseed = 1'b0; rif.en = 1'b0;
    for (int i = 0; i < NB; i++) m_b[i] = 8'h00;
    m_cnt = 0; m_run = 0;

    // reset, then idle with rst low
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 8'h55, 0, 1);
    check("rst_r", rif.r, '0);
    check("rst_seed_ready", W'(rif.seed_ready), W'(0));
    cyc(0, 0, 0, 0, 1);
    check("ready_after_rst", W'(rif.seed_ready), W'(1));

    // seed 0x01..0x1B
    for (int i = 0; i < NB; i++) cyc(0, 1, 8'(i + 1), 0, 0);
    for (int i = 0; i < NB; i++) exp_w[8*i +: 8] = 8'(i + 1);
    check("seed_seq", rif.r, exp_w);
    check("seed_seq_valid", W'(rif.r_valid), W'(1));
    check("seed_seq_ready", W'(rif.seed_ready), W'(0));

    // single step: fb = 01^04^0D^1B = 13
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < NB - 1; i++) exp_w[8*i +: 8] = 8'(i + 2);
    exp_w[W-8 +: 8] = 8'h13;
    check("step1", rif.r, exp_w);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'hFF, 0, 0);
    check("hold5", rif.r, exp_w);

    // reseed with en: no step, back to LOAD
    cyc(0, 0, 0, 1, 1);
    check("reseed_no_step", rif.r, exp_w);
    check("reseed_valid", W'(rif.r_valid), W'(0));
    check("reseed_ready", W'(rif.seed_ready), W'(1));
    for (int i = 0; i < NB; i++) cyc(0, 1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < NB; i++) exp_w[8*i +: 8] = 8'(8'hA0 + i);
    check("reload_a0", rif.r, exp_w);

    // all-zero seed falls back to 1, then never returns to zero
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < NB; i++) cyc(0, 1, 8'h00, 0, 0);
    check("zero_guard", rif.r, W'(1));
    check("zero_guard_valid", W'(rif.r_valid), W'(1));
    for (int i = 0; i < NB; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("nonzero", W'(rif.r == '0), W'(0));
    end

    // toggled seed_valid with en pulses and junk in the gaps
    for (int i = 0; i < NB; i++) rb[i] = 8'($urandom);
    rb[0] = rb[0] | 8'h01;
    cyc(0, 0, 0, 1, 0);
    k = 0;
    for (int c = 0; c < 2 * NB - 1; c++) begin
      if (c % 2 == 0) begin
        cyc(0, 1, rb[k], 0, 0);
        k++;
      end else begin
        cyc(0, 0, 8'($urandom), 0, 1);
      end
    end
    for (int i = 0; i < NB; i++) exp_w[8*i +: 8] = rb[i];
    check("gapped_seed", rif.r, exp_w);

    // reset mid-load after 10 bytes, then a full fresh seed
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'($urandom), 0, 0);
    cyc(1, 1, 8'h77, 0, 0);
    check("midload_rst_r", rif.r, '0);
    check("midload_rst_valid", W'(rif.r_valid), W'(0));
    for (int i = 0; i < NB; i++) rb[i] = 8'($urandom);
    rb[5] = 8'h5A;
    for (int i = 0; i < NB; i++) cyc(0, 1, rb[i], 0, 0);
    for (int i = 0; i < NB; i++) exp_w[8*i +: 8] = rb[i];
    check("post_rst_seed", rif.r, exp_w);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
          ($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
